// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, the queued-write entry type and the address
// decode helper used by the writeback controller and by decode-side logic.
package rf_wb_pkg;

  localparam int AW_DEF   = 3;
  localparam int DW_DEF   = 32;
  localparam int NREG_DEF = 2 ** AW_DEF;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG_DEF-1:0] onehot_addr(input logic [AW_DEF-1:0] addr);
    return NREG_DEF'(1) << addr;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: in-order circular queue of pending register writes.
// Up to two pushes per cycle (push0 lands ahead of push1) and one pop.
// The caller guarantees pushes never exceed the free space.
module rf_wb_fifo #(
  parameter int AW    = 3,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    push0,
  input  logic [AW-1:0]           push0_addr,
  input  logic [DW-1:0]           push0_data,
  input  logic                    push1,
  input  logic [AW-1:0]           push1_addr,
  input  logic [DW-1:0]           push1_data,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic [AW-1:0]           head_addr,
  output logic [DW-1:0]           head_data,
  output logic [DEPTH-1:0]        ent_valid,
  output logic [DEPTH*AW-1:0]     ent_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr1;
  logic          pop_eff;

  assign wr_ptr1   = wr_ptr + PW'(push0);
  assign pop_eff   = pop && (count != '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      rd_ptr <= rd_ptr + PW'(pop_eff);
      count  <= count + (PW+1)'(push0) + (PW+1)'(push1) - (PW+1)'(pop_eff);
    end
  end

  // Entry storage; contents are only meaningful where ent_valid is set.
  always_ff @(posedge clk) begin
    if (push0) begin
      addr_q[wr_ptr] <= push0_addr;
      data_q[wr_ptr] <= push0_data;
    end
    if (push1) begin
      addr_q[wr_ptr1] <= push1_addr;
      data_q[wr_ptr1] <= push1_data;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i]          = ({1'b0, PW'(i) - rd_ptr} < count);
      ent_addr[i*AW +: AW]  = addr_q[i];
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: write-side master for the register file. Merges load
// and ALU results into an in-order queue, retires one write per cycle on a
// registered rf_* port and publishes a pending-write mask for hazard stalls.
// Optional macro RF_WB_BYPASS_EN: with an empty queue the first accepted
// beat goes straight to rf_* one cycle earlier.
module rf_writeback_ctrl
  import rf_wb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DW-1:0]     alu_data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_wa,
  output logic [DW-1:0]     rf_wd,
  output logic [2**AW-1:0]  pend,
  output logic              empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_FREE = CW'(DEPTH - 1);

  logic [CW-1:0]       count;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data;
  logic [DEPTH-1:0]    ent_valid;
  logic [DEPTH*AW-1:0] ent_addr;
  logic                ld_acc;
  logic                alu_acc;
  logic                pop;
  logic                push0;
  logic                push1;
  logic [AW-1:0]       push0_addr;
  logic [DW-1:0]       push0_data;

  // Readiness looks only at the registered count; a same-cycle pop earns no credit.
  assign ld_ready  = n_rst && (count < FULL);
  assign alu_ready = n_rst && ((count < ONE_FREE) || ((count == ONE_FREE) && !ld_valid));
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign pop       = (count != '0);

`ifdef RF_WB_BYPASS_EN
  logic          byp;
  logic [AW-1:0] byp_addr;
  logic [DW-1:0] byp_data;

  assign byp      = (count == '0) && (ld_acc || alu_acc);
  assign byp_addr = ld_acc ? ld_addr : alu_addr;
  assign byp_data = ld_acc ? ld_data : alu_data;

  // With an empty queue the load (or lone ALU beat) bypasses; a concurrent ALU beat still queues.
  always_comb begin
    push0      = ld_acc;
    push0_addr = ld_addr;
    push0_data = ld_data;
    push1      = alu_acc;
    if (count == '0) begin
      push0      = ld_acc && alu_acc;
      push0_addr = alu_addr;
      push0_data = alu_data;
      push1      = 1'b0;
    end
  end
`else
  assign push0      = ld_acc;
  assign push0_addr = ld_addr;
  assign push0_data = ld_data;
  assign push1      = alu_acc;
`endif

  rf_wb_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .push0      (push0),
    .push0_addr (push0_addr),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_addr (alu_addr),
    .push1_data (alu_data),
    .pop        (pop),
    .count      (count),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  // Registered write port: retire the queue head, otherwise drop we and hold address/data.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (pop) begin
      rf_we <= 1'b1;
      rf_wa <= head_addr;
      rf_wd <= head_data;
`ifdef RF_WB_BYPASS_EN
    end else if (byp) begin
      rf_we <= 1'b1;
      rf_wa <= byp_addr;
      rf_wd <= byp_data;
`endif
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Pending mask: every live queue entry plus the write currently on rf_*.
  always_comb begin
    pend = '0;
    if (n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i]) pend[ent_addr[i*AW +: AW]] = 1'b1;
      end
      if (rf_we) pend[rf_wa] = 1'b1;
    end
  end

  assign empty = !n_rst || ((count == '0) && !rf_we);

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Write-side master for the 8 x 32-bit processor register file; sole driver of the file's we/wa/wd port.
- Accepts results from two producers, the ALU and the load unit, over valid/ready channels.
- Buffers results in a small in-order queue and retires at most one register write per cycle.
- Exports a per-register pending-write mask so decode can stall on read-after-write hazards.

Parameters:
- DW, 32, data width of one register.
- AW, 3, register address width; 2**AW registers.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- n_rst  in  1  reset; synchronous, active-low.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load result accepted this cycle when ld_valid is also high.
- ld_addr  in  AW  load destination register.
- ld_data  in  DW  load result.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- rf_we  out  1  register file write enable; registered.
- rf_wa  out  AW  register file write address; registered.
- rf_wd  out  DW  register file write data; registered.
- pend  out  2**AW  bit i set when a write to register i is queued or on rf_*.
- empty  out  1  queue empty and rf_we low.

Behaviour:
- Reset: when n_rst is low at a rising edge, the queue count, rf_we, rf_wa and rf_wd all clear to 0. Takes priority over all other activity.
- Outputs while n_rst is low: ld_ready=0, alu_ready=0, pend=0, empty=1. In-flight entries are discarded with no register write; a reset arriving mid-drain simply loses the queued results.
- Ready rules depend only on the registered count and ld_valid; there is no credit for a same-cycle pop.
  - ld_ready = (count < DEPTH).
  - alu_ready = (count <= DEPTH-2) or (count == DEPTH-1 and !ld_valid).
- Acceptance: both channels may be accepted in the same cycle. The load result is enqueued first and the ALU result second, so the ALU write lands last if both target the same register.
- Load priority: with exactly one free slot and both channels valid, only the load is accepted.
- Drain: in any cycle with count > 0, the head is popped into rf_wa/rf_wd and rf_we=1 in the next cycle. Otherwise rf_we=0 next cycle; rf_wa/rf_wd hold their last values.
- Latency: result accepted in cycle N (empty queue) -> rf_we high in cycle N+2 -> register file updated at the edge ending N+2.
- Push and pop in the same cycle are legal; count' = count + pushes - pop.
- Queue storage is a circular buffer; pointers wrap at DEPTH.
- pend is combinational from state: OR over valid queue entries plus (rf_we ? rf_wa : none). Duplicate writes to one register keep the bit set until the last of them leaves rf_*.
- empty = (count == 0) and !rf_we.
- No register is special; register 0 is written like any other.
- Inputs must be held stable while valid && !ready; the block does not check this.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - When count==0 in cycle N, the first accepted beat (the load if both are valid) goes straight to rf_*, with rf_we=1 in cycle N+1.
  - A concurrently accepted ALU beat is enqueued normally.
  - pend includes the bypassed beat from cycle N+1.
- Undefined: every result passes through the queue (latency N+2).

Decomposition:
- Package rf_wb_pkg holds:
  - AW_DEF=3 and DW_DEF=32.
  - typedef wb_entry_t {addr[AW], data[DW]}.
  - Function onehot_addr(addr) returning a 2**AW mask.
- Sub-module rf_wb_fifo: synchronous circular queue with 0/1/2 pushes and 0/1 pop per cycle. It outputs count, head entry, and the per-entry valid/addr vectors used to build pend.
- rf_writeback_ctrl holds the ready logic, the output register, the bypass path and the pend OR-reduction.

Test Plan:
- Single load, queue empty:
  - Stimulus: ld_valid with addr=3, data=32'h1234_5678 in cycle 0.
  - Without bypass: rf_we=1, wa=3, wd=32'h12345678 in cycle 2; pend=8'h08 in cycles 1-2; empty=1 in cycle 3.
  - With RF_WB_BYPASS_EN: rf_we in cycle 1.
- Dual accept, same register:
  - Stimulus: ld {5, 32'hA} and alu {5, 32'hB} both valid in cycle 0.
  - Response: both readies high; writes appear in cycles 2 and 3 in order A then B; pend[5] stays 1 until cycle 3 ends.
- Full / backpressure:
  - Stimulus: hold alu_valid for 6 cycles with addrs 0-5; stall nothing.
  - Response: no write is lost; addresses exit in order 0-5 on consecutive rf_we cycles.
  - Stimulus: pre-fill to count=3, then assert both valids.
  - Response: ld_ready=1, alu_ready=0; the ALU beat is accepted the following cycle.
- Wrap-around:
  - Stimulus: stream 10 alternating ld/alu beats, data 0..9.
  - Response: rf_wd sequence 0..9 exactly; pointers wrap twice with no corruption.
- Reset mid-operation:
  - Stimulus: fill the queue with 4 entries, drive n_rst=0 for one cycle.
  - Response: next cycle rf_we=0, pend=0, empty=1, readies high; no stale write afterwards.
- Idle hold:
  - Stimulus: no valids for 5 cycles after a write to register 7 with 32'hAAAA55AA.
  - Response: rf_we=0, rf_wa=7 and rf_wd=32'hAAAA55AA held, pend=0.
